// File: rtl/jtl_pulse_scheduler.sv
// jtl_pulse_scheduler
//   Shares one toggle-encoded JTL output line between N_REQ toggle-encoded
//   pulse sources. Each source's pulses are counted into a saturating pending
//   counter and replayed round-robin onto q, with at least GAP clocks between
//   successive q toggles.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          toggle-encoded pulse inputs (each bit transition = 1 pulse)
//   enable       1 = new grants allowed
//   clear_ovf    synchronous clear of all overflow flags
//   q            toggle-encoded shared output line
//   grant_valid  1-cycle strobe, high in the cycle q toggles
//   grant_id     requester served by the most recent grant (held otherwise)
//   pending_any  registered OR of all non-zero pending counters
//   overflow     sticky per-requester pulse-lost flags
module jtl_pulse_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned GAP   = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic             clear_ovf,
    output logic             q,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic             pending_any,
    output logic [N_REQ-1:0] overflow
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nxt;

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] req_prev;
    logic             armed;
    logic [N_REQ-1:0] edge_c;

    logic [CNT_W-1:0] pend     [N_REQ];
    logic [CNT_W-1:0] pend_nxt [N_REQ];
    logic [N_REQ-1:0] nz_c;
    logic [N_REQ-1:0] ovf_set_c;
    logic             any_nxt_c;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   pick_c;
    logic             pick_valid_c;
    logic             grant_en_c;
    logic [N_REQ-1:0] grant_c;

    // Input capture. Until armed, req_prev follows req directly so that a
    // level held across reset is seen as "no change" rather than a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            req_prev <= '0;
            armed    <= 1'b0;
        end else begin
            req_q    <= req;
            req_prev <= armed ? req_q : req;
            armed    <= 1'b1;
        end
    end

    always_comb begin
        edge_c = armed ? (req_q ^ req_prev) : '0;
    end

    // Non-zero flags for the arbiter.
    always_comb begin
        nz_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            nz_c[i] = (pend[i] != '0);
        end
    end

    // Round-robin search: first non-empty requester at ptr, ptr+1, ... mod N_REQ.
    always_comb begin
        pick_valid_c = 1'b0;
        pick_c       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!pick_valid_c && nz_c[i] && (((32'(ptr) + k) % N_REQ) == i)) begin
                    pick_valid_c = 1'b1;
                    pick_c       = IDW'(i);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gap   <= '0;
        end else begin
            state <= state_nxt;
            gap   <= gap_nxt;
        end
    end

    // FSM next state: a grant opens a holdoff window of GAP-1 extra clocks.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        case (state)
            IDLE: begin
                if (grant_en_c && (GAP > 1)) begin
                    state_nxt = HOLDOFF;
                    gap_nxt   = GAP_W'(GAP - 1);
                end
            end
            HOLDOFF: begin
                gap_nxt = gap - GAP_W'(1);
                if (gap == GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gap_nxt   = '0;
            end
        endcase
    end

    // FSM outputs: grants only issue from IDLE with enable set.
    always_comb begin
        grant_en_c = (state == IDLE) && enable && pick_valid_c;
        grant_c    = grant_en_c ? (N_REQ'(1) << pick_c) : '0;
    end

    // Pending counter update; a pulse arriving at a full counter is lost.
    always_comb begin
        ovf_set_c = '0;
        any_nxt_c = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pend_nxt[i] = pend[i];
            if (edge_c[i] && !grant_c[i]) begin
                if (pend[i] == CNT_MAX) begin
                    ovf_set_c[i] = 1'b1;
                end else begin
                    pend_nxt[i] = pend[i] + CNT_W'(1);
                end
            end else if (grant_c[i] && !edge_c[i]) begin
                pend_nxt[i] = pend[i] - CNT_W'(1);
            end
            any_nxt_c = any_nxt_c | (pend_nxt[i] != '0);
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                pend[i] <= '0;
            end
            ptr         <= '0;
            q           <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            pending_any <= 1'b0;
            overflow    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                pend[i] <= pend_nxt[i];
            end
            pending_any <= any_nxt_c;
            // Set wins over clear for the same bit.
            overflow    <= (clear_ovf ? '0 : overflow) | ovf_set_c;
            grant_valid <= grant_en_c;
            if (grant_en_c) begin
                q        <= ~q;
                grant_id <= pick_c;
                ptr      <= (32'(pick_c) == (N_REQ - 1)) ? '0 : (pick_c + IDW'(1));
            end
        end
    end

endmodule

// File: tb/tb_jtl_pulse_scheduler.sv
// Scoreboard bench for jtl_pulse_scheduler: directed pulse patterns push the
// expected grants (id, q level, cycle) into queues; a monitor pops and checks
// them whenever grant_valid is seen.
module tb_jtl_pulse_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic       en_a = 1'b1;
    logic       en_b = 1'b1;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;

    logic       q_a, gv_a, pa_a;
    logic [1:0] id_a;
    logic [3:0] ovf_a;
    logic       q_b, gv_b, pa_b;
    logic [1:0] id_b;
    logic [3:0] ovf_b;

    jtl_pulse_scheduler #(.N_REQ(4), .CNT_W(3), .GAP(4), .IDW(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .enable(en_a), .clear_ovf(clr_a),
        .q(q_a), .grant_valid(gv_a), .grant_id(id_a), .pending_any(pa_a), .overflow(ovf_a)
    );

    jtl_pulse_scheduler #(.N_REQ(4), .CNT_W(3), .GAP(1), .IDW(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .enable(en_b), .clear_ovf(clr_b),
        .q(q_b), .grant_valid(gv_b), .grant_id(id_b), .pending_any(pa_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] id;
        logic       q;
        int         cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    logic eq_a = 1'b0;
    logic eq_b = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input logic [1:0] id, input int c);
        eq_a = ~eq_a;
        sb_a.push_back('{id, eq_a, c});
    endtask

    task automatic push_b(input logic [1:0] id, input int c);
        eq_b = ~eq_b;
        sb_b.push_back('{id, eq_b, c});
    endtask

    // Monitor: every grant strobe must match the head of its scoreboard.
    always @(negedge clk) begin
        if (gv_a) begin
            if (sb_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL grant_a unexpected: id=%0d at cycle %0d, required no grant", id_a, cyc);
            end else begin
                ea = sb_a.pop_front();
                check("grant_a id", 32'(id_a), 32'(ea.id));
                check("grant_a q", 32'(q_a), 32'(ea.q));
                check("grant_a cycle", cyc, ea.cyc);
            end
        end
        if (gv_b) begin
            if (sb_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL grant_b unexpected: id=%0d at cycle %0d, required no grant", id_b, cyc);
            end else begin
                eb = sb_b.pop_front();
                check("grant_b id", 32'(id_b), 32'(eb.id));
                check("grant_b q", 32'(q_b), 32'(eb.q));
                check("grant_b cycle", cyc, eb.cyc);
            end
        end
    end

    // Wait for both scoreboards to empty, bounded; then idle to catch strays.
    task automatic drain(input string name, input int bound);
        int t = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && t < bound) begin
            @(negedge clk);
            #1;
            t++;
        end
        vectors++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            miscompares++;
            $display("FAIL %s drain: %0d/%0d grants outstanding, required 0/0", name, sb_a.size(), sb_b.size());
            sb_a.delete();
            sb_b.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        eq_a  = 1'b0;
        eq_b  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int m;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst q", 32'(q_a), 0);
        check("rst grant_valid", 32'(gv_a), 0);
        check("rst grant_id", 32'(id_a), 0);
        check("rst pending_any", 32'(pa_a), 0);
        check("rst overflow", 32'(ovf_a), 0);
        check("rst q_b", 32'(q_b), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single pulse on req[2]
        @(negedge clk);
        n = cyc;
        req_a[2] = ~req_a[2];
        push_a(2'd2, n + 3);
        @(negedge clk);
        @(negedge clk);
        check("single pending_any set", 32'(pa_a), 1);
        @(negedge clk);
        check("single pending_any clear", 32'(pa_a), 0);
        drain("single", 40);

        // All four requesters at once
        do_reset();
        @(negedge clk);
        n = cyc;
        req_a = ~req_a;
        push_a(2'd0, n + 3);
        push_a(2'd1, n + 7);
        push_a(2'd2, n + 11);
        push_a(2'd3, n + 15);
        drain("simultaneous", 60);
        check("simultaneous final q", 32'(q_a), 0);

        // Round-robin: req[1] every clock for 20 clocks, req[3] once
        do_reset();
        @(negedge clk);
        n = cyc;
        req_a[1] = ~req_a[1];
        req_a[3] = ~req_a[3];
        push_a(2'd1, n + 3);
        push_a(2'd3, n + 7);
        for (int g = 0; g < 10; g++) push_a(2'd1, n + 11 + 4 * g);
        for (int j = 1; j < 20; j++) begin
            @(negedge clk);
            req_a[1] = ~req_a[1];
        end
        drain("round_robin", 120);
        check("round_robin overflow", 32'(ovf_a), 32'h2);

        // Saturation with enable low, then release
        do_reset();
        @(negedge clk);
        en_a = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            req_a[0] = ~req_a[0];
        end
        repeat (4) @(negedge clk);
        check("sat pending_any", 32'(pa_a), 1);
        check("sat overflow set", 32'(ovf_a), 32'h1);
        check("sat no grant while disabled", 32'(q_a), 0);
        @(negedge clk);
        m = cyc;
        en_a = 1'b1;
        for (int g = 0; g < 7; g++) push_a(2'd0, m + 1 + 4 * g);
        drain("saturation", 60);
        check("sat pending_any drained", 32'(pa_a), 0);
        check("sat overflow sticky", 32'(ovf_a), 32'h1);
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("sat overflow cleared", 32'(ovf_a), 0);

        // GAP=1: three pending pulses on req[1] -> back-to-back grants
        @(negedge clk);
        en_b = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            req_b[1] = ~req_b[1];
        end
        repeat (3) @(negedge clk);
        check("gap1 pending_any", 32'(pa_b), 1);
        @(negedge clk);
        m = cyc;
        en_b = 1'b1;
        push_b(2'd1, m + 1);
        push_b(2'd1, m + 2);
        push_b(2'd1, m + 3);
        drain("gap1", 30);
        check("gap1 final q", 32'(q_b), 1);
        check("gap1 pending_any drained", 32'(pa_b), 0);

        // Reset during HOLDOFF; a level held across reset is not a pulse
        do_reset();
        @(negedge clk);
        n = cyc;
        req_a[0] = ~req_a[0];
        req_a[1] = ~req_a[1];
        push_a(2'd0, n + 3);
        repeat (4) @(negedge clk);
        check("holdoff q before reset", 32'(q_a), 1);
        check("holdoff pending before reset", 32'(pa_a), 1);
        rst_n = 1'b0;
        req_a[3] = ~req_a[3];
        eq_a = 1'b0;
        eq_b = 1'b0;
        #1;
        check("async rst q", 32'(q_a), 0);
        check("async rst grant_valid", 32'(gv_a), 0);
        check("async rst grant_id", 32'(id_a), 0);
        check("async rst pending_any", 32'(pa_a), 0);
        check("async rst overflow", 32'(ovf_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post reset q", 32'(q_a), 0);
        check("post reset pending_any", 32'(pa_a), 0);
        check("post reset queue", sb_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
